kl_arb2: RTL

- Two-requester KLink arbiter/router that shares a single MLink transceiver's KLink TX/RX ports between two masters (e.g. I-side and D-side cache refill engines).
- TX side: round-robin grant, held for the whole multi-beat burst.
- Requester index is tagged into ID bit 4 on the way out.
- RX side: responses are demultiplexed back to the owning requester using that bit.
- Sits between the cache/bus masters and the transceiver's KLink generic TX/RX ports.

---
 rtl/kl_arb2.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/kl_arb2.sv
// Two-requester KLink arbiter: round-robin TX grant locked for a whole burst,
// requester index carried in ID bit 4, RX responses steered back by that bit.
module kl_arb2 #(
    parameter logic RR_INIT         = 1'b0,
    parameter int   MAX_BURST_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_tx_addr,
    input  logic        m0_tx_den,
    input  logic [63:0] m0_tx_data,
    input  logic [2:0]  m0_tx_size,
    input  logic [3:0]  m0_tx_id,
    input  logic        m0_tx_valid,
    output logic        m0_tx_ready,

    input  logic [31:0] m1_tx_addr,
    input  logic        m1_tx_den,
    input  logic [63:0] m1_tx_data,
    input  logic [2:0]  m1_tx_size,
    input  logic [3:0]  m1_tx_id,
    input  logic        m1_tx_valid,
    output logic        m1_tx_ready,

    output logic [31:0] m0_rx_addr,
    output logic [63:0] m0_rx_data,
    output logic        m0_rx_den,
    output logic [2:0]  m0_rx_size,
    output logic [3:0]  m0_rx_id,
    output logic        m0_rx_valid,
    input  logic        m0_rx_ready,

    output logic [31:0] m1_rx_addr,
    output logic [63:0] m1_rx_data,
    output logic        m1_rx_den,
    output logic [2:0]  m1_rx_size,
    output logic [3:0]  m1_rx_id,
    output logic        m1_rx_valid,
    input  logic        m1_rx_ready,

    output logic [31:0] kl_tx_addr,
    output logic        kl_tx_den,
    output logic [63:0] kl_tx_data,
    output logic [2:0]  kl_tx_size,
    output logic [4:0]  kl_tx_id,
    output logic        kl_tx_valid,
    input  logic        kl_tx_ready,

    input  logic [31:0] kl_rx_addr,
    input  logic [63:0] kl_rx_data,
    input  logic        kl_rx_den,
    input  logic [2:0]  kl_rx_size,
    input  logic [4:0]  kl_rx_id,
    input  logic        kl_rx_valid,
    output logic        kl_rx_ready
);
    localparam int BW = MAX_BURST_WIDTH + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic            grant_reg, grant_next;
    logic            last_gnt_reg, last_gnt_next;
    logic            first_reg, first_next;
    logic [BW-1:0]   beats_left_reg, beats_left_next;

    logic [31:0]     req_addr  [2];
    logic            req_den   [2];
    logic [63:0]     req_data  [2];
    logic [2:0]      req_size  [2];
    logic [3:0]      req_id    [2];
    logic [1:0]      req_valid;
    logic [1:0]      tx_ready_vec;
    logic [1:0]      rx_valid_vec;
    logic [1:0]      rx_ready_vec;
    logic [BW-1:0]   first_beats;
    logic            rx_sel;

    // Beats in a transaction; anything without data, or narrower than a beat, is one beat.
    function automatic logic [BW-1:0] burst_beats(input logic den, input logic [2:0] size);
        logic [7:0] bytes;
        logic [7:0] beats;
        bytes = 8'd1 << size;
        beats = bytes >> 3;
        if (!den || beats == 8'd0) begin
            return BW'(1);
        end
        return BW'(beats);
    endfunction

    assign req_addr[0]  = m0_tx_addr;
    assign req_den[0]   = m0_tx_den;
    assign req_data[0]  = m0_tx_data;
    assign req_size[0]  = m0_tx_size;
    assign req_id[0]    = m0_tx_id;
    assign req_valid[0] = m0_tx_valid;
    assign req_addr[1]  = m1_tx_addr;
    assign req_den[1]   = m1_tx_den;
    assign req_data[1]  = m1_tx_data;
    assign req_size[1]  = m1_tx_size;
    assign req_id[1]    = m1_tx_id;
    assign req_valid[1] = m1_tx_valid;

    // The fields are muxed unconditionally; only kl_tx_valid qualifies them.
    assign kl_tx_addr = req_addr[grant_reg];
    assign kl_tx_den  = req_den[grant_reg];
    assign kl_tx_data = req_data[grant_reg];
    assign kl_tx_size = req_size[grant_reg];
    assign kl_tx_id   = {grant_reg, req_id[grant_reg]};

    assign first_beats = burst_beats(kl_tx_den, kl_tx_size);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_gnt_reg   <= RR_INIT;
            first_reg      <= 1'b1;
            beats_left_reg <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_gnt_reg   <= last_gnt_next;
            first_reg      <= first_next;
            beats_left_reg <= beats_left_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_gnt_next   = last_gnt_reg;
        first_next      = first_reg;
        beats_left_next = beats_left_reg;
        kl_tx_valid     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    state_next = ST_GRANT;
                    first_next = 1'b1;
                    grant_next = (req_valid == 2'b11) ? ~last_gnt_reg : req_valid[1];
                end
            end
            ST_GRANT: begin
                kl_tx_valid = req_valid[grant_reg];
                if (kl_tx_valid && kl_tx_ready) begin
                    if (first_reg) begin
                        if (first_beats == BW'(1)) begin
                            state_next    = ST_IDLE;
                            last_gnt_next = grant_reg;
                        end else begin
                            beats_left_next = first_beats - BW'(1);
                            first_next      = 1'b0;
                        end
                    end else begin
                        beats_left_next = beats_left_reg - BW'(1);
                        if (beats_left_reg == BW'(1)) begin
                            state_next    = ST_IDLE;
                            last_gnt_next = grant_reg;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Response routing carries no state: ID bit 4 alone picks the owner.
    assign rx_sel          = kl_rx_id[4];
    assign rx_ready_vec[0] = m0_rx_ready;
    assign rx_ready_vec[1] = m1_rx_ready;
    assign kl_rx_ready     = rx_ready_vec[rx_sel];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign tx_ready_vec[gi] = (state_reg == ST_GRANT) && (grant_reg == 1'(gi)) && kl_tx_ready;
            assign rx_valid_vec[gi] = kl_rx_valid && (rx_sel == 1'(gi));
        end
    endgenerate

    assign m0_tx_ready = tx_ready_vec[0];
    assign m1_tx_ready = tx_ready_vec[1];
    assign m0_rx_valid = rx_valid_vec[0];
    assign m1_rx_valid = rx_valid_vec[1];

    assign m0_rx_addr = kl_rx_addr;
    assign m0_rx_data = kl_rx_data;
    assign m0_rx_den  = kl_rx_den;
    assign m0_rx_size = kl_rx_size;
    assign m0_rx_id   = kl_rx_id[3:0];
    assign m1_rx_addr = kl_rx_addr;
    assign m1_rx_data = kl_rx_data;
    assign m1_rx_den  = kl_rx_den;
    assign m1_rx_size = kl_rx_size;
    assign m1_rx_id   = kl_rx_id[3:0];

endmodule
